mac_dot_seq: RTL
================

// Module: mac_dot_seq
// PURPOSE
//  Sequencer for a shared pipelined multiply-accumulate datapath: computes one unsigned
//  dot product sum(A[base_a+i]*B[base_b+i]), i=0..len-1, per start command.
//  Fetches operands from two external synchronous-read memories (1-cycle read latency).
//  Clears the accumulator per job, drains the pipeline, and returns the result on a valid/ready port.
// PARAMETERS
//  WIDTH   8  operand width (unsigned)
//  ADDR_W  6  operand memory address width; max vector length = 2**ADDR_W
//  ACC_W   2*WIDTH+ADDR_W (localparam)  accumulator/result width, overflow-free at max len
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset, asynchronous, active-high
//  start      in   1         job request, sampled only in IDLE
//  len        in   ADDR_W+1  vector length 0..2**ADDR_W; larger values clamp to 2**ADDR_W
//  base_a     in   ADDR_W    start address of vector A
//  base_b     in   ADDR_W    start address of vector B
//  busy       out  1         high in every state except IDLE
//  mem_rd_en  out  1         read strobe to both operand memories
//  addr_a     out  ADDR_W    A read address
//  addr_b     out  ADDR_W    B read address
//  rdata_a    in   WIDTH     A read data, valid the cycle after mem_rd_en
//  rdata_b    in   WIDTH     B read data, valid the cycle after mem_rd_en
//  res_valid  out  1         result available
//  res_ready  in   1         consumer accepts result
//  result     out  ACC_W     dot-product result
// BEHAVIOUR
//  Reset: state IDLE; busy, mem_rd_en, res_valid = 0; addr_a, addr_b, result, accumulator,
//   product register, valid pipe = 0. Reset mid-job aborts it; no partial result is emitted.
//  FSM: IDLE -> ISSUE on start with len!=0. Latch base/len, clear accumulator and counter.
//       IDLE -> DONE on start with len==0 (result 0, res_valid next cycle).
//       ISSUE: one read per cycle, mem_rd_en=1, addr_x = base_x+i mod 2**ADDR_W (wraps);
//              after the len-th issue -> DRAIN.
//       DRAIN: exactly 2 cycles with mem_rd_en=0, then -> DONE.
//       DONE: res_valid=1; result holds stable until res_valid&&res_ready, then -> IDLE.
//  Pipeline: valid bit v1 follows mem_rd_en by 1 cycle (operand stage).
//   Product register p <= rdata_a*rdata_b when v1; v2 <= v1.
//   acc <= acc + p when v2. Zero-extend all operands; no wrap for in-range len.
//  Latency: start sampled in cycle 0 -> reads in cycles 1..len -> res_valid in cycle len+3.
//  start outside IDLE is ignored, including in the DONE handshake cycle.
//   Earliest next acceptance is the cycle after the handshake.
//  Inputs base/len are don't-care after the accepting cycle.
//  Back-to-back jobs: the accumulator is cleared on acceptance, never by the result handshake.
// STRUCTURE
//  Package mac_pkg: state enum {IDLE, ISSUE, DRAIN, DONE}, ACC_W function/localparam,
//   DRAIN_CYCLES=2.
//  Sub-module mac_pipe: product register + accumulator with clr/en and v1/v2 valid pipe,
//   width-parameterised.
//  mac_dot_seq: FSM, length clamp, element counter, address generators, result port.
// TESTING
//  1 len=4, base 0, A=[1,2,3,4], B=[5,6,7,8], res_ready=1 -> reads cycles 1..4, result=70,
//    res_valid in cycle 7 for 1 cycle.
//  2 Same job with res_ready low 3 cycles -> result stays 70 and res_valid stays high;
//    start pulses in DONE are ignored; IDLE follows the handshake.
//  3 len=0 -> no mem_rd_en; res_valid in cycle 1 with result=0.
//  4 base_a=62, base_b=0, len=4 (ADDR_W=6) -> addr_a=62,63,0,1 and addr_b=0,1,2,3,
//    with correct sum.
//  5 WIDTH=8, all operands 255, len=64 -> result 4161600, no overflow; len=100 is clamped
//    to 64 reads.
//  6 rst asserted in ISSUE cycle 2 -> all outputs 0 immediately. A new len=2 job afterwards
//    (A=[3,3], B=[4,4]) -> result 24, no residue from the aborted job.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product sequencer and its
// multiply-accumulate pipeline.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  // Cycles between the last operand read and a settled accumulator.
  localparam int DRAIN_CYCLES = 2;

  // Accumulator width that cannot overflow for 2**addr_w full-scale products.
  function automatic int acc_width(input int width, input int addr_w);
    return 2 * width + addr_w;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate pipeline: product register, then accumulator,
// each qualified by a valid bit that trails the operand-memory read strobe.
module mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [ACC_W-1:0]   acc
);

  logic               v1;
  logic               v2;
  logic [2*WIDTH-1:0] p;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, like real flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      p   <= '0;
      acc <= '0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
      if (v1) begin
        p <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      end
      if (clr) begin
        acc <= '0;
      end else if (v2) begin
        acc <= acc + {{(ACC_W - 2 * WIDTH){1'b0}}, p};
      end
    end
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: fetches A/B operand pairs from two synchronous-read
// memories, feeds the MAC pipeline, drains it and presents the sum on a valid/ready port.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 6,
  localparam int ACC_W = acc_width(WIDTH, ADDR_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  rdata_a,
  input  logic [WIDTH-1:0]  rdata_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result
);

  localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] DRAIN_TOP = (ADDR_W + 1)'(DRAIN_CYCLES - 1);

  state_t          state;
  state_t          state_next;
  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] cnt;
  logic            accept;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign accept      = (state == IDLE) && start;

  assign busy      = (state != IDLE);
  assign mem_rd_en = (state == ISSUE);
  assign res_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the default assignment first means every path drives state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len_clamped == '0) ? DONE : ISSUE;
      ISSUE:   if (cnt == (ADDR_W + 1)'(1)) state_next = DRAIN;
      DRAIN:   if (cnt == '0) state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt counts remaining reads in ISSUE, then is reused for the drain delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      addr_a <= '0;
      addr_b <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= len_clamped;
          addr_a <= base_a;
          addr_b <= base_b;
        end
        ISSUE: begin
          addr_a <= addr_a + 1'b1;
          addr_b <= addr_b + 1'b1;
          cnt    <= (cnt == (ADDR_W + 1)'(1)) ? DRAIN_TOP : cnt - 1'b1;
        end
        DRAIN: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Accumulator is cleared on acceptance only, so DONE holds the result steady.
  mac_pipe #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .in_valid(mem_rd_en),
    .a       (rdata_a),
    .b       (rdata_b),
    .acc     (result)
  );

endmodule
